itch_feed_arbiter: RTL and testbench

- Shares the single byte-serial ITCH message parser between NUM_CH length-prefixed ingress byte streams.
- Each stream carries messages framed as a 2-byte big-endian length L followed by L body bytes. The body's first byte is the message type.
- Per message, the block grants one channel round-robin and collects the body into an internal buffer.
- It then replays the body to the parser as a gap-free burst with start_msg, end_msg and valid.
- The parser flags any gap as an invalid message, so the burst must never stall.

---
 rtl/itch_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/itch_feed_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_itch_feed_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// rtl/itch_pkg.sv - shared states and ITCH message constants for the feed arbiter
package itch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        COLLECT,
        EMIT,
        DROP
    } state_t;

    localparam int ITCH_MAX_LEN = 64;

    localparam logic [7:0] MSG_A = 8'h41;
    localparam logic [7:0] MSG_E = 8'h45;
    localparam logic [7:0] MSG_X = 8'h58;
    localparam logic [7:0] MSG_D = 8'h44;

    localparam int LEN_A = 36;
    localparam int LEN_E = 31;
    localparam int LEN_X = 23;
    localparam int LEN_D = 19;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first requester at or after ptr
module rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic [$clog2(NUM_CH)-1:0] gnt_idx,
    output logic                      any_req
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NUM_CH;
            if (req[idx]) begin
                gnt_idx = ($clog2(NUM_CH))'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/itch_feed_arbiter.sv
// rtl/itch_feed_arbiter.sv - message-granular arbiter replaying buffered ITCH bodies as gap-free bursts
module itch_feed_arbiter
    import itch_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int MAX_LEN = ITCH_MAX_LEN,
    parameter int LEN_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*8-1:0]       in_data,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    output logic                      start_msg,
    output logic                      end_msg,
    output logic [7:0]                message,
    output logic                      valid,
    output logic [$clog2(NUM_CH)-1:0] grant,
    output logic                      busy,
    output logic [31:0]               msg_count,
    output logic [15:0]               drop_count
);

    localparam int G_W   = $clog2(NUM_CH);
    localparam int IDX_W = $clog2(MAX_LEN);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [G_W-1:0]   grant_q, grant_d, ptr_q, ptr_d;
    logic [31:0]      msg_count_q, msg_count_d;
    logic [15:0]      drop_count_q, drop_count_d;
    logic             valid_q, valid_d, start_q, start_d, end_q, end_d;
    logic [7:0]       message_q, message_d;
    logic [7:0]       mem_q [MAX_LEN];

    logic [G_W-1:0]   arb_idx;
    logic             any_req;
    logic             xfer;
    logic [7:0]       in_byte;
    logic [LEN_W-1:0] full_len, len_last, cnt_nxt;
    logic             at_last;
    logic [G_W-1:0]   ptr_next;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (arb_idx),
        .any_req (any_req)
    );

    assign in_byte  = in_data[{grant_q, 3'b000} +: 8];
    assign xfer     = in_valid[grant_q] && in_ready[grant_q];
    assign full_len = {len_q[LEN_W-1:8], in_byte};
    assign len_last = len_q - LEN_W'(1);
    assign cnt_nxt  = cnt_q + LEN_W'(1);
    assign at_last  = (cnt_q == len_last);
    assign ptr_next = (grant_q == G_W'(NUM_CH - 1)) ? '0 : grant_q + G_W'(1);

    always_comb begin
        in_ready = '0;
        if (state_q == LEN_HI || state_q == LEN_LO || state_q == COLLECT || state_q == DROP) begin
            in_ready[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            ptr_q        <= '0;
            msg_count_q  <= '0;
            drop_count_q <= '0;
            valid_q      <= 1'b0;
            start_q      <= 1'b0;
            end_q        <= 1'b0;
            message_q    <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            msg_count_q  <= msg_count_d;
            drop_count_q <= drop_count_d;
            valid_q      <= valid_d;
            start_q      <= start_d;
            end_q        <= end_d;
            message_q    <= message_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == COLLECT && xfer) begin
            mem_q[cnt_q[IDX_W-1:0]] <= in_byte;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = LEN_HI;
            LEN_HI:  if (xfer) state_d = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (full_len == '0)                    state_d = IDLE;
                    else if (full_len > LEN_W'(MAX_LEN))   state_d = DROP;
                    else                                   state_d = COLLECT;
                end
            end
            COLLECT: if (xfer && at_last) state_d = EMIT;
            EMIT:    if (at_last) state_d = IDLE;
            DROP:    if (xfer && at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Parser-side registers are loaded from the next state so valid is high exactly while in EMIT.
    always_comb begin
        len_d        = len_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        msg_count_d  = msg_count_q;
        drop_count_d = drop_count_q;
        valid_d      = 1'b0;
        start_d      = 1'b0;
        end_d        = 1'b0;
        message_d    = '0;
        case (state_q)
            IDLE: if (any_req) grant_d = arb_idx;
            LEN_HI: if (xfer) len_d = {in_byte, 8'h00};
            LEN_LO: begin
                if (xfer) begin
                    len_d = full_len;
                    cnt_d = '0;
                    if (full_len == '0 && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
                end
            end
            COLLECT: begin
                if (xfer) begin
                    cnt_d = cnt_nxt;
                    if (at_last) begin
                        cnt_d     = '0;
                        valid_d   = 1'b1;
                        start_d   = 1'b1;
                        end_d     = (len_q == LEN_W'(1));
                        // A 1-byte body is still in flight on the bus, not yet in mem_q.
                        message_d = (len_q == LEN_W'(1)) ? in_byte : mem_q[0];
                    end
                end
            end
            EMIT: begin
                if (at_last) begin
                    cnt_d       = '0;
                    msg_count_d = msg_count_q + 32'd1;
                    ptr_d       = ptr_next;
                end else begin
                    cnt_d     = cnt_nxt;
                    valid_d   = 1'b1;
                    end_d     = (cnt_nxt == len_last);
                    message_d = mem_q[cnt_nxt[IDX_W-1:0]];
                end
            end
            DROP: begin
                if (xfer) begin
                    cnt_d = cnt_nxt;
                    if (at_last) begin
                        cnt_d = '0;
                        ptr_d = ptr_next;
                        if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign start_msg  = start_q;
    assign end_msg    = end_q;
    assign message    = message_q;
    assign valid      = valid_q;
    assign grant      = grant_q;
    assign busy       = (state_q != IDLE);
    assign msg_count  = msg_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_itch_feed_arbiter.sv
// tb/tb_itch_feed_arbiter.sv - directed self-checking bench for itch_feed_arbiter
module tb_itch_feed_arbiter;
    import itch_pkg::*;

    localparam int NUM_CH = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_CH*8-1:0] in_data = '0;
    logic [NUM_CH-1:0]   in_valid = '0;
    logic [NUM_CH-1:0]   in_ready;
    logic                start_msg, end_msg, valid, busy;
    logic [7:0]          message;
    logic [0:0]          grant;
    logic [31:0]         msg_count;
    logic [15:0]         drop_count;

    itch_feed_arbiter #(.NUM_CH(NUM_CH), .MAX_LEN(64), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start_msg  (start_msg),
        .end_msg    (end_msg),
        .message    (message),
        .valid      (valid),
        .grant      (grant),
        .busy       (busy),
        .msg_count  (msg_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int        cur_len = 0;
    int        burst_lens[$];
    int        burst_grants[$];
    logic [7:0] got_bytes[$];
    int        gap_errs = 0;
    int        start_errs = 0;
    int        single_cycles = 0;
    int        first_valid_cyc = -1;
    int        last_acc_cyc = -1;

    logic [7:0] exp_bytes[$];
    int         exp_msg = 0;
    int         exp_drop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                if ((cur_len == 0) != start_msg) start_errs++;
                if (start_msg) begin
                    burst_grants.push_back(int'(grant));
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (start_msg && end_msg) single_cycles++;
                got_bytes.push_back(message);
                cur_len++;
                if (end_msg) begin
                    burst_lens.push_back(cur_len);
                    cur_len = 0;
                end
            end else if (cur_len != 0) begin
                gap_errs++;
                cur_len = 0;
            end
        end
    end

    task automatic clear_mon();
        burst_lens.delete();
        burst_grants.delete();
        got_bytes.delete();
        exp_bytes.delete();
        gap_errs = 0;
        start_errs = 0;
        single_cycles = 0;
        first_valid_cyc = -1;
    endtask

    // Length prefix plus body; body byte 0 is the type, the rest a seeded ramp.
    task automatic build(input int len, input logic [7:0] typ, input logic [7:0] seed,
                         input bit expect_out, inout logic [7:0] q[$]);
        logic [7:0] b;
        q.push_back(8'((len >> 8) & 255));
        q.push_back(8'(len & 255));
        for (int i = 0; i < len; i++) begin
            b = (i == 0) ? typ : 8'(seed + 8'(i));
            q.push_back(b);
            if (expect_out) exp_bytes.push_back(b);
        end
    endtask

    task automatic send(input int ch, input logic [7:0] q[$], input int stall_at, input int stall_n);
        int i = 0;
        int t = 0;
        while (i < q.size()) begin
            if (i == stall_at && stall_n > 0) begin
                in_valid[ch] = 1'b0;
                repeat (stall_n) @(posedge clk);
                #1;
                stall_n = 0;
            end
            in_valid[ch] = 1'b1;
            in_data[ch*8 +: 8] = q[i];
            @(negedge clk);
            if (in_ready[ch]) begin
                i++;
                last_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            t++;
            if (t > 3000) begin
                check("send_timeout", 32'(i), 32'(q.size()));
                break;
            end
        end
        in_valid[ch] = 1'b0;
    endtask

    task automatic wait_bursts(input int n);
        int t = 0;
        while (burst_lens.size() < n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        check("burst_wait", 32'(burst_lens.size()), 32'(n));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_bytes(input string tag);
        int bad = 0;
        check({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            if (got_bytes[i] !== exp_bytes[i]) bad++;
        check({tag, "_byte_errs"}, 32'(bad), 32'd0);
        check({tag, "_gaps"}, 32'(gap_errs), 32'd0);
        check({tag, "_start_errs"}, 32'(start_errs), 32'd0);
        check({tag, "_msg_count"}, msg_count, 32'(exp_msg));
        check({tag, "_drop_count"}, 32'(drop_count), 32'(exp_drop));
    endtask

    initial begin
        logic [7:0] q0[$];
        logic [7:0] q1[$];

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_start", 32'(start_msg), 0);
        check("rst_end", 32'(end_msg), 0);
        check("rst_message", 32'(message), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_msg_count", msg_count, 0);
        check("rst_drop_count", 32'(drop_count), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset during COLLECT of an A message abandons it silently.
        clear_mon();
        q0.delete();
        build(LEN_A, MSG_A, 8'h10, 1'b0, q0);
        q1 = q0[0:11];
        send(0, q1, -1, 0);
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("mid_rst_msg_count", msg_count, 0);
        check("mid_rst_drop_count", 32'(drop_count), 0);
        q1.delete();
        build(LEN_X, MSG_X, 8'h60, 1'b1, q1);
        send(1, q1, -1, 0);
        exp_msg = 1;
        wait_bursts(1);
        check("post_rst_len", 32'(burst_lens[0]), 32'(LEN_X));
        check("post_rst_grant", 32'(burst_grants[0]), 1);
        check_bytes("post_rst");

        // Simultaneous A messages on both channels with the pointer at 0.
        clear_mon();
        q0.delete();
        q1.delete();
        build(LEN_A, MSG_A, 8'h20, 1'b1, q0);
        build(LEN_A, MSG_A, 8'h80, 1'b1, q1);
        fork
            send(0, q0, -1, 0);
            send(1, q1, -1, 0);
        join
        exp_msg = 3;
        wait_bursts(2);
        check("dual_len0", 32'(burst_lens[0]), 36);
        check("dual_len1", 32'(burst_lens[1]), 36);
        check("dual_grant0", 32'(burst_grants[0]), 0);
        check("dual_grant1", 32'(burst_grants[1]), 1);
        check_bytes("dual");

        // D message on ch0 without stalls; first byte one cycle after the last accept.
        clear_mon();
        q0.delete();
        build(LEN_D, MSG_D, 8'h30, 1'b1, q0);
        send(0, q0, -1, 0);
        exp_msg = 4;
        wait_bursts(1);
        check("d_len", 32'(burst_lens[0]), 32'(LEN_D));
        check("d_first", 32'(got_bytes[0]), 32'(MSG_D));
        check("d_latency", 32'(first_valid_cyc), 32'(last_acc_cyc + 1));
        check_bytes("d");

        // E message on ch1 with a 3-cycle input stall mid-body.
        clear_mon();
        q1.delete();
        build(LEN_E, MSG_E, 8'h50, 1'b1, q1);
        send(1, q1, 17, 3);
        exp_msg = 5;
        wait_bursts(1);
        check("e_len", 32'(burst_lens[0]), 32'(LEN_E));
        check_bytes("e");

        // Oversize len=100 is consumed and dropped, then an X message follows.
        clear_mon();
        q0.delete();
        build(100, 8'hAA, 8'h00, 1'b0, q0);
        build(LEN_X, MSG_X, 8'h70, 1'b1, q0);
        send(0, q0, -1, 0);
        exp_msg = 6;
        exp_drop = 1;
        wait_bursts(1);
        check("x_len", 32'(burst_lens[0]), 32'(LEN_X));
        check("x_in_ready_idle", 32'(in_ready), 0);
        check_bytes("x");

        // len=0 is dropped, then a single-byte body gets start and end together.
        clear_mon();
        q0.delete();
        build(0, 8'h00, 8'h00, 1'b0, q0);
        build(1, MSG_A, 8'h00, 1'b1, q0);
        send(0, q0, -1, 0);
        exp_msg = 7;
        exp_drop = 2;
        wait_bursts(1);
        check("one_len", 32'(burst_lens[0]), 1);
        check("one_single", 32'(single_cycles), 1);
        check("one_byte", 32'(got_bytes[0]), 32'h41);
        check("end_valid", 32'(valid), 0);
        check("end_busy", 32'(busy), 0);
        check_bytes("one");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
